display_scan: RTL and testbench

Parametrised registered hex display driver for the datapath board. It presents one of NUM_CH data channels, such as the data bus and register-file read ports, on ceil(DATA_W/4) seven-segment digits and mirrors that channel on LEDs. It adds three things the previous combinational display lacked: a clocked manual/auto-rotate channel selector, a freeze (hold) snapshot, and a blinking status point. It sits between the datapath/controller and the board HEX/LED pins.

---
 rtl/display_pkg.sv | 29 ++
 rtl/hex7decoder.sv | 14 +
 rtl/display_scan.sv | 139 +++++++++++++
 tb/tb_display_scan.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared segment encodings for the hex display driver
// Holds the active-low seven-segment table for nibbles 0-F (bit 6 = segment g,
// bit 0 = segment a) and the decimal-point drive levels.
package display_pkg;

    // Index 0 is the rightmost element of the concatenation.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    localparam logic DP_ON  = 1'b0;
    localparam logic DP_OFF = 1'b1;

endpackage

// File: rtl/hex7decoder.sv
// rtl/hex7decoder.sv - nibble to active-low seven-segment decoder
// Ports:
//   hex  in  4  nibble to display
//   seg  out 7  active-low segments {g,f,e,d,c,b,a}
module hex7decoder
    import display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/display_scan.sv
// rtl/display_scan.sv - registered multi-channel hex display with rotate, hold and blink
// Ports:
//   CLK      in  1              system clock
//   RESETb   in  1              synchronous active-low reset
//   CH_DATA  in  NUM_CH*DATA_W  packed channels, channel k at [k*DATA_W +: DATA_W]
//   SEL      in  SEL_W          manual channel select
//   MODE     in  1              0 = manual, 1 = auto-rotate on tick
//   HOLDb    in  1              active-low freeze of the displayed value
//   DONE     in  1              controller done flag (steady decimal point)
//   TIME     in  TIME_W         current timestep
//   LED_B    out DATA_W         live value of the selected channel
//   DHEX     out NDIG*7         digit d at [d*7 +: 7], digit 0 = LS nibble
//   THEX     out 8              [6:0] timestep digit, [7] active-low decimal point
//   CH_IDX   out SEL_W          currently selected channel index
module display_scan
    import display_pkg::*;
#(
    parameter  int DATA_W = 10,
    parameter  int NUM_CH = 2,
    parameter  int TIME_W = 2,
    parameter  int DIV    = 25_000_000,
    localparam int NDIG   = (DATA_W + 3) / 4,
    localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     CLK,
    input  logic                     RESETb,
    input  logic [NUM_CH*DATA_W-1:0] CH_DATA,
    input  logic [SEL_W-1:0]         SEL,
    input  logic                     MODE,
    input  logic                     HOLDb,
    input  logic                     DONE,
    input  logic [TIME_W-1:0]        TIME,
    output logic [DATA_W-1:0]        LED_B,
    output logic [NDIG*7-1:0]        DHEX,
    output logic [7:0]               THEX,
    output logic [SEL_W-1:0]         CH_IDX
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              blink_q, blink_d;
    logic [SEL_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] disp_q, disp_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic              done_q, done_d;
    logic              holdb_q, holdb_d;

    logic              tick;
    logic [DATA_W-1:0] ch_sel;
    logic [NDIG*4-1:0] disp_pad;
    logic [3:0]        time_pad;
    logic              dp;

    always_comb begin
        ch_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx_q == SEL_W'(k)) begin
                ch_sel = CH_DATA[k*DATA_W +: DATA_W];
            end
        end
    end

    assign tick = (cnt_q == CNT_W'(DIV - 1));

    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        blink_d = tick ? ~blink_q : blink_q;

        idx_d = idx_q;
        if (NUM_CH == 1) begin
            idx_d = '0;
        end else if (MODE) begin
            if (tick) begin
                idx_d = (idx_q == SEL_W'(NUM_CH - 1)) ? '0 : idx_q + 1'b1;
            end
        end else if (32'(SEL) < NUM_CH) begin
            // An out-of-range manual select leaves the current channel in place.
            idx_d = SEL;
        end

        // Snapshot uses the live HOLDb so the freeze starts on the very next edge.
        disp_d  = HOLDb ? ch_sel : disp_q;
        time_d  = TIME;
        done_d  = DONE;
        holdb_d = HOLDb;
    end

    always_ff @(posedge CLK) begin
        if (!RESETb) begin
            cnt_q   <= '0;
            blink_q <= 1'b0;
            idx_q   <= '0;
            disp_q  <= '0;
            time_q  <= '0;
            done_q  <= 1'b0;
            holdb_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            time_q  <= time_d;
            done_q  <= done_d;
            holdb_q <= holdb_d;
        end
    end

    // DONE outranks the hold blink; blink high lights the point.
    always_comb begin
        if (done_q) begin
            dp = DP_ON;
        end else if (!holdb_q) begin
            dp = ~blink_q;
        end else begin
            dp = DP_OFF;
        end
    end

    assign disp_pad = (NDIG*4)'(disp_q);
    assign time_pad = 4'(time_q);

    for (genvar d = 0; d < NDIG; d++) begin : g_dig
        hex7decoder u_dig (
            .hex (disp_pad[d*4 +: 4]),
            .seg (DHEX[d*7 +: 7])
        );
    end

    hex7decoder u_time (
        .hex (time_pad),
        .seg (THEX[6:0])
    );

    assign THEX[7] = dp;
    assign LED_B   = ch_sel;
    assign CH_IDX  = idx_q;

endmodule

// File: tb/tb_display_scan.sv
// tb/tb_display_scan.sv - scoreboard bench for display_scan
module tb_display_scan;

    localparam int DATA_W = 10;
    localparam int NUM_CH = 3;
    localparam int TIME_W = 2;
    localparam int DIV    = 4;
    localparam int NDIG   = 3;
    localparam int SEL_W  = 2;

    localparam int F_IDX  = 0;
    localparam int F_LED  = 1;
    localparam int F_DHEX = 2;
    localparam int F_THEX = 3;

    localparam logic [31:0] ENC_000 = {11'd0, 7'h40, 7'h40, 7'h40};
    localparam logic [31:0] ENC_155 = {11'd0, 7'h79, 7'h12, 7'h12};
    localparam logic [31:0] ENC_2AB = {11'd0, 7'h24, 7'h08, 7'h03};
    localparam logic [31:0] ENC_3FF = {11'd0, 7'h30, 7'h0E, 7'h0E};

    logic                     clk = 1'b0;
    logic                     resetb;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [SEL_W-1:0]         sel;
    logic                     mode;
    logic                     holdb;
    logic                     done;
    logic [TIME_W-1:0]        time_in;
    logic [DATA_W-1:0]        led_b;
    logic [NDIG*7-1:0]        dhex;
    logic [7:0]               thex;
    logic [SEL_W-1:0]         ch_idx;

    display_scan #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .TIME_W (TIME_W),
        .DIV    (DIV)
    ) dut (
        .CLK     (clk),
        .RESETb  (resetb),
        .CH_DATA (ch_data),
        .SEL     (sel),
        .MODE    (mode),
        .HOLDb   (holdb),
        .DONE    (done),
        .TIME    (time_in),
        .LED_B   (led_b),
        .DHEX    (dhex),
        .THEX    (thex),
        .CH_IDX  (ch_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          fld;
        logic [31:0] val;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   rst_cyc = 0;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic expect_at(input int d, input int f, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc = cyc + d;
        e.fld = f;
        e.val = v;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic nxt(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] act(input int f);
        case (f)
            F_IDX:   act = 32'(ch_idx);
            F_LED:   act = 32'(led_b);
            F_DHEX:  act = 32'(dhex);
            default: act = 32'(thex);
        endcase
    endfunction

    function automatic logic [31:0] thex_blink(input int tgt);
        int  e;
        logic dpv;
        e   = tgt - rst_cyc;
        dpv = (((e / DIV) % 2) == 1) ? 1'b0 : 1'b1;
        return {24'd0, dpv, 7'h30};
    endfunction

    function automatic int idx_rot(input int tgt, input int base_e);
        return (((tgt - rst_cyc) / DIV) - (base_e / DIV)) % NUM_CH;
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                n_cmp++;
                if (sb[i].cyc < cyc || act(sb[i].fld) !== sb[i].val) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d got=%h want=%h", sb[i].nm, cyc,
                             act(sb[i].fld), sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        resetb  = 1'b0;
        ch_data = {10'h3C7, 10'h2AB, 10'h155};
        sel     = '0;
        mode    = 1'b0;
        holdb   = 1'b1;
        done    = 1'b0;
        time_in = '0;

        nxt();
        rst_cyc = cyc;
        n_cmp++;
        if (ch_idx !== 2'd0) begin
            n_bad++;
            $display("FAIL direct rst_idx got=%h", ch_idx);
        end
        n_cmp++;
        if (led_b !== 10'h155) begin
            n_bad++;
            $display("FAIL direct rst_led got=%h", led_b);
        end
        n_cmp++;
        if (thex !== 8'hC0) begin
            n_bad++;
            $display("FAIL direct rst_thex got=%h", thex);
        end
        expect_at(0, F_IDX,  32'd0,     "rst_idx");
        expect_at(0, F_LED,  32'h155,   "rst_led");
        expect_at(0, F_DHEX, ENC_000,   "rst_dhex");
        expect_at(0, F_THEX, 32'hC0,    "rst_thex");
        resetb = 1'b1;

        sel = 2'd1;
        expect_at(1, F_IDX,  32'd1,   "man_idx");
        expect_at(1, F_LED,  32'h2AB, "man_led");
        expect_at(1, F_DHEX, ENC_155, "man_dhex_lag");
        expect_at(2, F_DHEX, ENC_2AB, "man_dhex");
        nxt(2);
        n_cmp++;
        if (ch_idx !== 2'd1) begin
            n_bad++;
            $display("FAIL direct man_idx got=%h", ch_idx);
        end
        n_cmp++;
        if (led_b !== 10'h2AB) begin
            n_bad++;
            $display("FAIL direct man_led got=%h", led_b);
        end
        n_cmp++;
        if (32'(dhex) !== ENC_2AB) begin
            n_bad++;
            $display("FAIL direct man_dhex got=%h", dhex);
        end

        sel = 2'd3;
        expect_at(1, F_IDX, 32'd1,   "oor_idx1");
        expect_at(2, F_IDX, 32'd1,   "oor_idx2");
        expect_at(2, F_LED, 32'h2AB, "oor_led");
        nxt(2);

        sel     = 2'd2;
        time_in = 2'd3;
        expect_at(0, F_THEX, 32'hC0,  "time_pre");
        expect_at(1, F_IDX,  32'd2,   "sel2_idx");
        expect_at(1, F_LED,  32'h3C7, "sel2_led");
        expect_at(1, F_THEX, 32'hB0,  "time_thex");
        nxt(1);

        sel = 2'd0;
        nxt(2);
        expect_at(0, F_DHEX, ENC_155, "pre_hold_dhex");

        holdb         = 1'b0;
        ch_data[9:0]  = 10'h3FF;
        expect_at(0, F_LED,  32'h3FF, "hold_led");
        expect_at(1, F_DHEX, ENC_155, "hold_dhex1");
        expect_at(8, F_DHEX, ENC_155, "hold_dhex8");
        for (int d = 1; d <= 8; d++) expect_at(d, F_THEX, thex_blink(cyc + d), "hold_blink");
        nxt(8);

        holdb = 1'b1;
        expect_at(1, F_DHEX, ENC_3FF, "release_dhex");
        expect_at(1, F_THEX, 32'hB0,  "release_thex");
        nxt(2);

        holdb = 1'b0;
        done  = 1'b1;
        for (int d = 1; d <= 6; d++) expect_at(d, F_THEX, 32'h30, "done_dp");
        nxt(6);
        done = 1'b0;
        for (int d = 1; d <= 6; d++) expect_at(d, F_THEX, thex_blink(cyc + d), "done_off_blink");
        nxt(6);
        holdb = 1'b1;
        nxt(1);

        mode = 1'b1;
        base = cyc - rst_cyc;
        for (int d = 1; d <= 13; d++)
            expect_at(d, F_IDX, 32'(idx_rot(cyc + d, base)), "rot_idx");
        nxt(13);
        for (int k = 0; k < 12; k++) begin
            if (idx_rot(cyc, base) == 2) break;
            nxt(1);
        end
        expect_at(0, F_IDX, 32'd2, "rot_pre_rst");

        resetb = 1'b0;
        expect_at(1, F_IDX,  32'd0,   "mid_rst_idx");
        expect_at(1, F_LED,  32'h3FF, "mid_rst_led");
        expect_at(1, F_DHEX, ENC_000, "mid_rst_dhex");
        expect_at(1, F_THEX, 32'hC0,  "mid_rst_thex");
        nxt(1);
        rst_cyc = cyc;
        resetb  = 1'b1;
        expect_at(3, F_IDX, 32'd0, "post_rst_cnt3");
        expect_at(4, F_IDX, 32'd1, "post_rst_cnt4");
        nxt(6);

        for (int k = 0; k < 20 && sb.size() > 0; k++) nxt(1);
        while (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s never checked want=%h", sb[0].nm, sb[0].val);
            void'(sb.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
